// File: rtl/usr_pkg.sv
// Shared receiver-mode encodings and FSM state type for the universal shift
// register transmitter.
package usr_pkg;

  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_SHL  = 2'b01;
  localparam logic [1:0] SEL_SHR  = 2'b10;
  localparam logic [1:0] SEL_LOAD = 2'b11;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Receiver mode for a word's direction: LSB-first words shift right.
  function automatic logic [1:0] dir_sel(input logic dir);
    return dir ? SEL_SHR : SEL_SHL;
  endfunction

endpackage

// File: rtl/usr_tx_hold_reg.sv
// One-deep {data, dir} holding buffer. Push is only legal while empty and pop
// only while full, so the two never coincide.
module usr_tx_hold_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  input  logic             dir_in,
  output logic [WIDTH-1:0] data,
  output logic             dir,
  output logic             full
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data <= '0;
      dir  <= 1'b0;
      full <= 1'b0;
    end else if (push) begin
      data <= data_in;
      dir  <= dir_in;
      full <= 1'b1;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/universal_shift_tx.sv
// Parallel-to-serial transmitter: serialises each accepted word one bit per
// clock and drives the receiver's sel so it reassembles the word.
module universal_shift_tx
  import usr_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] inp,
  input  logic             inp_dir,
  input  logic             inp_valid,
  output logic             inp_ready,
  output logic             serial_out,
  output logic [1:0]       sel_out,
  output logic             busy,
  output logic             frame_done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  // Handshake: a word is accepted on any rising edge where inp_valid and
  // inp_ready are both high; inp/inp_dir must hold while valid waits on ready.
  logic             hold_full;
  logic [WIDTH-1:0] hold_data;
  logic             hold_dir;
  logic             push;
  logic             load;

  state_t           state, state_next;
  logic [CW-1:0]    count, count_next;
  logic [WIDTH-1:0] shifter, shifter_next;
  logic             dir_q, dir_next;
  logic             serial_next;
  logic [1:0]       sel_next;

  assign inp_ready  = !hold_full && !reset;
  assign push       = inp_valid && inp_ready;
  assign busy       = (state == SHIFT);
  assign frame_done = (state == SHIFT) && (count == '0);

  usr_tx_hold_reg #(.WIDTH(WIDTH)) u_hold (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (load),
    .data_in (inp),
    .dir_in  (inp_dir),
    .data    (hold_data),
    .dir     (hold_dir),
    .full    (hold_full)
  );

  // The shifter always holds the bits not yet presented; the bit on
  // serial_out has already been consumed from it.
  always_comb begin
    state_next   = state;
    count_next   = count;
    shifter_next = shifter;
    dir_next     = dir_q;
    serial_next  = serial_out;
    sel_next     = sel_out;
    load         = 1'b0;

    case (state)
      IDLE: begin
        if (hold_full) load = 1'b1;
      end
      SHIFT: begin
        if (count == '0) begin
          if (hold_full) begin
            load = 1'b1;
          end else begin
            state_next  = IDLE;
            serial_next = 1'b0;
            sel_next    = SEL_HOLD;
          end
        end else begin
          serial_next  = dir_q ? shifter[0] : shifter[WIDTH-1];
          shifter_next = dir_q ? (shifter >> 1) : (shifter << 1);
          count_next   = count - 1'b1;
        end
      end
      default: begin
        state_next  = IDLE;
        serial_next = 1'b0;
        sel_next    = SEL_HOLD;
      end
    endcase

    if (load) begin
      state_next   = SHIFT;
      dir_next     = hold_dir;
      count_next   = LAST_IDX;
      serial_next  = hold_dir ? hold_data[0] : hold_data[WIDTH-1];
      shifter_next = hold_dir ? (hold_data >> 1) : (hold_data << 1);
      sel_next     = dir_sel(hold_dir);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      shifter    <= '0;
      dir_q      <= 1'b0;
      serial_out <= 1'b0;
      sel_out    <= SEL_HOLD;
    end else begin
      state      <= state_next;
      count      <= count_next;
      shifter    <= shifter_next;
      dir_q      <= dir_next;
      serial_out <= serial_next;
      sel_out    <= sel_next;
    end
  end

endmodule

// File: tb/tb_universal_shift_tx.sv
// Bench for universal_shift_tx: a model receiver rebuilds words from
// serial_out/sel_out and a monitor compares them with the accepted-word queue.
module tb_universal_shift_tx;

  localparam int WIDTH = 4;
  localparam int W = WIDTH + 1;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] inp;
  logic             inp_dir;
  logic             inp_valid;
  logic             inp_ready;
  logic             serial_out;
  logic [1:0]       sel_out;
  logic             busy;
  logic             frame_done;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q[$];

  universal_shift_tx #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .inp        (inp),
    .inp_dir    (inp_dir),
    .inp_valid  (inp_valid),
    .inp_ready  (inp_ready),
    .serial_out (serial_out),
    .sel_out    (sel_out),
    .busy       (busy),
    .frame_done (frame_done)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input logic [WIDTH-1:0] w, input logic d, output int waited);
    @(negedge clk);
    inp = w;
    inp_dir = d;
    inp_valid = 1'b1;
    waited = 0;
    while (!inp_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!inp_ready) begin
      check("accept_timeout", 1, 0);
      inp_valid = 1'b0;
    end else begin
      @(posedge clk);
      exp_q.push_back({d, w});
    end
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      inp_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || busy) && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("drain", (exp_q.size() != 0 || busy), 0);
  endtask

  // ---------------- scoreboard monitor with model receiver ----------------
  logic [WIDTH-1:0] rx;
  int bit_cnt;

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (reset) begin
      rx = '0;
      bit_cnt = 0;
    end else begin
      check("sel_legal", (sel_out == 2'b11), 0);
      if (!busy) begin
        check("idle_sel", sel_out, 0);
        check("idle_serial", serial_out, 0);
      end
      if (sel_out == 2'b01) rx = {rx[WIDTH-2:0], serial_out};
      if (sel_out == 2'b10) rx = {serial_out, rx[WIDTH-1:1]};
      if (sel_out != 2'b00) begin
        bit_cnt++;
        if (exp_q.size() == 0) check("unexpected_bit", 1, 0);
        else check("bit_sel", sel_out, exp_q[0][WIDTH] ? 2 : 1);
      end
      if (frame_done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("rx_word", rx, e[WIDTH-1:0]);
          check("frame_len", bit_cnt, WIDTH);
        end
        bit_cnt = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int w1, w2, w3;
    int run, fd, t;
    logic gap;

    reset = 1'b1;
    inp = '0;
    inp_dir = 1'b0;
    inp_valid = 1'b0;

    // Reset held for three cycles.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_serial", serial_out, 0);
      check("rst_sel", sel_out, 0);
      check("rst_busy", busy, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_ready", inp_ready, 0);
    end
    reset = 1'b0;
    #1;
    check("ready_after_release", inp_ready, 1);
    check("busy_after_release", busy, 0);

    // Single words, both directions.
    send(4'b1011, 1'b0, w1); idle(1); drain();
    send(4'b1011, 1'b1, w1); idle(1); drain();

    // Held valid: 9 (MSB-first) then 6 (LSB-first) with no gap.
    fork
      begin
        send(4'h9, 1'b0, w1);
        send(4'h6, 1'b1, w2);
        idle(1);
      end
      begin
        t = 0;
        do begin
          @(negedge clk);
          t++;
        end while (sel_out == 2'b00 && t < 50);
        run = 1;
        fd = frame_done ? 1 : 0;
        gap = 1'b0;
        for (int i = 0; i < 7; i++) begin
          @(negedge clk);
          if (sel_out == 2'b00) gap = 1'b1;
          if (!gap) run++;
          if (frame_done) fd++;
        end
        check("stream_run", run, 8);
        check("stream_frames", fd, 2);
      end
    join
    drain();

    // Three words offered while busy: the third must stall on inp_ready.
    send(4'h3, 1'b0, w1);
    send(4'hC, 1'b1, w2);
    send(4'h7, 1'b0, w3);
    idle(1);
    check("ready_stall", (w3 > 0), 1);
    drain();

    // Reset after two bits of 4'hA: partial word discarded.
    send(4'hA, 1'b0, w1);
    idle(1);
    t = 0;
    while (sel_out == 2'b00 && t < 50) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("abort_sel", sel_out, 0);
    check("abort_serial", serial_out, 0);
    check("abort_frame_done", frame_done, 0);
    check("abort_busy", busy, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    send(4'h5, 1'b0, w1); idle(1); drain();

    // Randomised words, directions and gaps.
    for (int i = 0; i < 24; i++) begin
      send(WIDTH'($urandom_range(0, (1 << WIDTH) - 1)), 1'($urandom_range(0, 1)), w1);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 6));
    end
    idle(1);
    drain();
    check("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
